// File: rtl/prm_edge_check_if.sv
// Bus between the roadmap builder / obstacle grid store and the PRM edge checker.
// The master side issues edge requests and returns grid occupancy; the slave is the checker.
interface prm_edge_check_if #(
    parameter int STEPPERS_NUM = 6,
    parameter int AXIS_BITS    = 3,
    parameter int LOG_SAMPLES  = 4
);
    localparam int GRID_AW = STEPPERS_NUM * AXIS_BITS;

    logic                        start;
    logic                        startReady;
    logic [32*STEPPERS_NUM-1:0]  startPose;
    logic [32*STEPPERS_NUM-1:0]  endPose;
    logic                        abort;
    logic                        gridRdEn;
    logic [GRID_AW-1:0]          gridAddr;
    logic                        gridRdData;
    logic                        busy;
    logic                        done;
    logic                        collide;
    logic [LOG_SAMPLES:0]        hitStep;

    modport master (
        output start, startPose, endPose, abort, gridRdData,
        input  startReady, gridRdEn, gridAddr, busy, done, collide, hitStep
    );

    modport slave (
        input  start, startPose, endPose, abort, gridRdData,
        output startReady, gridRdEn, gridAddr, busy, done, collide, hitStep
    );
endinterface

// File: rtl/prm_edge_check.sv
// PRM edge-validity engine: walks the joint-space segment start->end in 2^LOG_SAMPLES
// steps, looks each quantised pose up in the obstacle grid and reports the first hit.
module prm_edge_check #(
    parameter int STEPPERS_NUM = 6,
    parameter int AXIS_BITS    = 3,
    parameter int POS_SHIFT    = 16,
    parameter int LOG_SAMPLES  = 4
) (
    input  logic            CLK,
    input  logic            RST_n,
    prm_edge_check_if.slave bus
);
    localparam int GRID_AW = STEPPERS_NUM * AXIS_BITS;
    localparam int ACC_W   = 33 + LOG_SAMPLES;
    localparam int SAMPLES = 1 << LOG_SAMPLES;
    localparam logic [LOG_SAMPLES:0] LAST_K = (LOG_SAMPLES + 1)'(SAMPLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [AXIS_BITS-1:0] axis_field(input logic [31:0] pos);
        return pos[POS_SHIFT +: AXIS_BITS];
    endfunction

    // Arithmetic shift floors toward minus infinity; only the low 32 bits matter
    // because start + offset always lands back inside [start, end].
    function automatic logic [31:0] floor_step(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] q;
        q = acc >>> LOG_SAMPLES;
        return q[31:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_delta(input logic signed [32:0] d);
        return {{(ACC_W-33){d[32]}}, d};
    endfunction

    logic [1:0]                r_state;
    logic [LOG_SAMPLES:0]      r_k;
    logic                      r_gridRdEn;
    logic [GRID_AW-1:0]        r_gridAddr;
    logic                      r_done;
    logic                      r_collide;
    logic [LOG_SAMPLES:0]      r_hitStep;
    logic                      r_vld_p1;
    logic [LOG_SAMPLES:0]      r_step_p1;

    logic [31:0]               r_start [STEPPERS_NUM];
    logic signed [32:0]        r_delta [STEPPERS_NUM];
    logic signed [ACC_W-1:0]   r_acc   [STEPPERS_NUM];

    logic signed [32:0]        w_delta_in [STEPPERS_NUM];
    logic signed [ACC_W-1:0]   w_acc_next [STEPPERS_NUM];
    logic [GRID_AW-1:0]        w_addr_start;
    logic [GRID_AW-1:0]        w_addr_next;
    logic                      w_accept;
    logic                      w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < STEPPERS_NUM; gi++) begin : g_axis
            assign w_delta_in[gi] = $signed({1'b0, bus.endPose[32*gi +: 32]})
                                  - $signed({1'b0, bus.startPose[32*gi +: 32]});
            assign w_acc_next[gi] = r_acc[gi] + sext_delta(r_delta[gi]);
            assign w_addr_start[AXIS_BITS*gi +: AXIS_BITS] = axis_field(bus.startPose[32*gi +: 32]);
            assign w_addr_next[AXIS_BITS*gi +: AXIS_BITS]  = axis_field(r_start[gi] + floor_step(w_acc_next[gi]));
        end
    endgenerate

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    // p1: occupancy for the read tagged by r_vld_p1/r_step_p1 is on gridRdData now
    assign w_hit    = r_vld_p1 && bus.gridRdData;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_gridRdEn <= 1'b0;
            r_gridAddr <= '0;
            r_done     <= 1'b0;
            r_collide  <= 1'b0;
            r_hitStep  <= '0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_ISSUE;
                        r_k        <= '0;
                        r_gridRdEn <= 1'b1;
                        r_gridAddr <= w_addr_start;
                        r_vld_p1   <= 1'b0;
                        r_collide  <= 1'b0;
                        r_hitStep  <= '0;
                    end
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (bus.abort) begin
                        r_state    <= ST_IDLE;
                        r_gridRdEn <= 1'b0;
                        r_vld_p1   <= 1'b0;
                    end else if (w_hit) begin
                        r_state    <= ST_DONE;
                        r_gridRdEn <= 1'b0;
                        r_vld_p1   <= 1'b0;
                        r_collide  <= 1'b1;
                        r_hitStep  <= r_step_p1;
                        r_done     <= 1'b1;
                    end else if (r_state == ST_DRAIN) begin
                        r_state    <= ST_DONE;
                        r_vld_p1   <= 1'b0;
                        r_collide  <= 1'b0;
                        r_hitStep  <= '0;
                        r_done     <= 1'b1;
                    end else begin
                        r_vld_p1 <= r_gridRdEn;
                        if (r_k == LAST_K) begin
                            r_state    <= ST_DRAIN;
                            r_gridRdEn <= 1'b0;
                        end else begin
                            r_k        <= r_k + 1'b1;
                            r_gridAddr <= w_addr_next;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // p0: interpolation state for the step currently on the grid bus
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            for (int i = 0; i < STEPPERS_NUM; i++) begin
                r_start[i] <= bus.startPose[32*i +: 32];
                r_delta[i] <= w_delta_in[i];
                r_acc[i]   <= '0;
            end
        end else if (r_state == ST_ISSUE && r_k != LAST_K) begin
            for (int i = 0; i < STEPPERS_NUM; i++) begin
                r_acc[i] <= w_acc_next[i];
            end
        end
        r_step_p1 <= r_k;
    end

    assign bus.startReady = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.gridRdEn   = r_gridRdEn;
    assign bus.gridAddr   = r_gridAddr;
    assign bus.done       = r_done;
    assign bus.collide    = r_collide;
    assign bus.hitStep    = r_hitStep;
endmodule
